// File: rtl/boxhead_gfx_pkg.sv
// Shared graphics definitions: blitter state encoding, screen geometry, colour key,
// and the sprite ROM image generator used by sprite_rom.
package boxhead_gfx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAW  = 2'd1,
        FLUSH = 2'd2
    } blit_state_e;

    localparam int          SCREEN_W_PX   = 640;
    localparam int          SCREEN_H_PX   = 480;
    localparam logic [15:0] KEY_COLOR_565 = 16'hF81F;

    // Sprite image: 0 solid green, 1 blue with a keyed top-left pixel,
    // 2 grey with a white left column, others an asymmetric id/row/col pattern.
    function automatic logic [15:0] sprite_pixel(input int id, input int row, input int col);
        logic [15:0] pix;
        pix = 16'h0000;
        if (id == 0) begin
            pix = 16'h07E0;
        end else if (id == 1) begin
            pix = (row == 0 && col == 0) ? KEY_COLOR_565 : 16'h001F;
        end else if (id == 2) begin
            pix = (col == 0) ? 16'hFFFF : 16'h8410;
        end else if (((row + col + id) & 7) == 0) begin
            pix = KEY_COLOR_565;
        end else begin
            pix = {id[3:0], row[5:0], col[5:0]};
        end
        return pix;
    endfunction

endpackage

// File: rtl/sprite_rom.sv
// Synchronous single-port sprite ROM, one-cycle read latency.
// Contents come from boxhead_gfx_pkg::sprite_pixel, addressed as {id, row, col}.
module sprite_rom
    import boxhead_gfx_pkg::*;
#(
    parameter int SPRITE_W = 32,
    parameter int SPRITE_H = 32,
    parameter int SPRITE_N = 16,
    parameter int ADDR_W   = $clog2(SPRITE_N * SPRITE_W * SPRITE_H)
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] addr,
    output logic [15:0]       data
);

    localparam int COL_W = $clog2(SPRITE_W);
    localparam int ROW_W = $clog2(SPRITE_H);
    localparam int ID_W  = ADDR_W - ROW_W - COL_W;

    logic [15:0] data_d;
    logic [15:0] data_q;

    always_comb begin
        data_d = sprite_pixel(int'(addr[ADDR_W-1 -: ID_W]),
                              int'(addr[COL_W +: ROW_W]),
                              int'(addr[COL_W-1:0]));
    end

    always_ff @(posedge clk) begin
        data_q <= data_d;
    end

    assign data = data_q;

endmodule

// File: rtl/sprite_blitter.sv
// Sprite blitter: walks one sprite from ROM and streams clipped, colour-keyed pixels
// to the SRAM hidden-frame write port. Optional horizontal mirror under BLIT_FLIP_EN.
module sprite_blitter
    import boxhead_gfx_pkg::*;
#(
    parameter int          SPRITE_W  = 32,
    parameter int          SPRITE_H  = 32,
    parameter int          SPRITE_N  = 16,
    parameter int          SCREEN_W  = SCREEN_W_PX,
    parameter int          SCREEN_H  = SCREEN_H_PX,
    parameter logic [15:0] KEY_COLOR = KEY_COLOR_565
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        frame_clk,
    // A command transfers on any clk edge where cmd_valid and cmd_ready are both high;
    // cmd_ready is high exactly while IDLE and never depends on cmd_valid.
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic [9:0]                  cmd_x,
    input  logic [9:0]                  cmd_y,
    input  logic [$clog2(SPRITE_N)-1:0] cmd_id,
    input  logic                        cmd_flip,
    output logic [9:0]                  program_x,
    output logic [9:0]                  program_y,
    output logic [15:0]                 program_data,
    output logic                        done,
    output logic                        overrun,
    output logic [1:0]                  dbg_state
);

    localparam int COL_W  = $clog2(SPRITE_W);
    localparam int ROW_W  = $clog2(SPRITE_H);
    localparam int ID_W   = $clog2(SPRITE_N);
    localparam int ADDR_W = ID_W + ROW_W + COL_W;

    blit_state_e      state_q, state_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [9:0]       x_q, x_d;
    logic [9:0]       y_q, y_d;
    logic [ID_W-1:0]  id_q, id_d;
    logic             frame_q, frame_prev_q;
    logic             frame_edge;
    logic             pix_valid_q, pix_valid_d;
    logic [COL_W-1:0] pix_col_q, pix_col_d;
    logic [ROW_W-1:0] pix_row_q, pix_row_d;
    logic [9:0]       program_x_q, program_x_d;
    logic [9:0]       program_y_q, program_y_d;
    logic [15:0]      program_data_q, program_data_d;
    logic [COL_W-1:0] rom_col;
    logic [15:0]      rom_data;
    logic [10:0]      x_sum, y_sum;

`ifdef BLIT_FLIP_EN
    logic flip_q, flip_d;

    always_comb begin
        flip_d = flip_q;
        if (state_q == IDLE && cmd_valid) begin
            flip_d = cmd_flip;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            flip_q <= 1'b0;
        end else begin
            flip_q <= flip_d;
        end
    end

    // For a power-of-two width, W-1-col is the bitwise complement of col.
    assign rom_col = flip_q ? ~col_q : col_q;
`else
    logic unused_cmd_flip;
    assign unused_cmd_flip = cmd_flip;
    assign rom_col         = col_q;
`endif

    assign frame_edge = frame_q & ~frame_prev_q;

    sprite_rom #(
        .SPRITE_W (SPRITE_W),
        .SPRITE_H (SPRITE_H),
        .SPRITE_N (SPRITE_N),
        .ADDR_W   (ADDR_W)
    ) u_rom (
        .clk  (clk),
        .addr ({id_q, row_q, rom_col}),
        .data (rom_data)
    );

    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        x_d         = x_q;
        y_d         = y_q;
        id_d        = id_q;
        pix_valid_d = 1'b0;
        pix_col_d   = col_q;
        pix_row_d   = row_q;
        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    x_d     = cmd_x;
                    y_d     = cmd_y;
                    id_d    = cmd_id;
                    col_d   = '0;
                    row_d   = '0;
                    state_d = DRAW;
                end
            end
            DRAW: begin
                if (frame_edge) begin
                    state_d = IDLE;
                end else begin
                    pix_valid_d = 1'b1;
                    col_d       = col_q + COL_W'(1);
                    if (col_q == COL_W'(SPRITE_W - 1)) begin
                        row_d = row_q + ROW_W'(1);
                        if (row_q == ROW_W'(SPRITE_H - 1)) begin
                            state_d = FLUSH;
                        end
                    end
                end
            end
            FLUSH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Write-back: only a visible, non-key pixel moves the outputs, so holding
    // re-presents the last pixel and never an unintended coordinate.
    always_comb begin
        program_x_d    = program_x_q;
        program_y_d    = program_y_q;
        program_data_d = program_data_q;
        x_sum          = {1'b0, x_q} + 11'(pix_col_q);
        y_sum          = {1'b0, y_q} + 11'(pix_row_q);
        if (pix_valid_q && !frame_edge && rom_data != KEY_COLOR &&
            x_sum < 11'(SCREEN_W) && y_sum < 11'(SCREEN_H)) begin
            program_x_d    = x_sum[9:0];
            program_y_d    = y_sum[9:0];
            program_data_d = rom_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            col_q          <= '0;
            row_q          <= '0;
            x_q            <= '0;
            y_q            <= '0;
            id_q           <= '0;
            frame_q        <= 1'b0;
            frame_prev_q   <= 1'b0;
            pix_valid_q    <= 1'b0;
            pix_col_q      <= '0;
            pix_row_q      <= '0;
            program_x_q    <= '0;
            program_y_q    <= '0;
            program_data_q <= '0;
        end else begin
            state_q        <= state_d;
            col_q          <= col_d;
            row_q          <= row_d;
            x_q            <= x_d;
            y_q            <= y_d;
            id_q           <= id_d;
            frame_q        <= frame_clk;
            frame_prev_q   <= frame_q;
            pix_valid_q    <= pix_valid_d;
            pix_col_q      <= pix_col_d;
            pix_row_q      <= pix_row_d;
            program_x_q    <= program_x_d;
            program_y_q    <= program_y_d;
            program_data_q <= program_data_d;
        end
    end

    assign cmd_ready    = (state_q == IDLE);
    assign done         = (state_q == FLUSH) && !frame_edge;
    assign overrun      = (state_q != IDLE) && frame_edge;
    assign program_x    = program_x_q;
    assign program_y    = program_y_q;
    assign program_data = program_data_q;
    assign dbg_state    = state_q;

endmodule
